// File: rtl/traffic_pkg.sv
// Shared encodings for the farm-road traffic light system: light codes used by
// the controller and its sensor front end, plus the sensor-call FSM states.
package traffic_pkg;

  typedef logic [2:0] light_t;

  localparam light_t GREEN  = 3'b001;
  localparam light_t YELLOW = 3'b010;
  localparam light_t RED    = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALL   = 2'd1,
    SERVED = 2'd2,
    FAULT  = 2'd3
  } sensor_state_e;

  // Anything other than the exact GREEN code (including invalid codes) is not green.
  function automatic logic is_green(input light_t light);
    return light == GREEN;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debounce filter: the filtered
// level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);

  logic            sync1_q;
  logic            sync2_q;
  logic            filt_q;
  logic            filt_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = ~filt_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/farmway_sensor_conditioner.sv
// Farm-road detector front end: debounces the raw detector, latches a vehicle
// call until the farmway goes green, flags a stuck detector and counts arrivals.
module farmway_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned STUCK_CYCLES    = 1024,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sensor_raw,
  input  logic [2:0]       light_farmway,
  output logic             sensor,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             stuck_fault
);

  localparam int unsigned ST_W = $clog2(STUCK_CYCLES + 1);

  logic             filt;
  logic             filt_prev_q;
  logic             filt_rise;
  logic             green;
  logic             stuck_hit;
  logic [ST_W-1:0]  stuck_cnt_q;
  logic [ST_W-1:0]  stuck_cnt_d;
  logic [CNT_W-1:0] vcnt_q;
  logic [CNT_W-1:0] vcnt_d;
  logic             sensor_q;
  logic             sensor_d;
  sensor_state_e    state_q;
  sensor_state_e    state_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rstn  (rstn),
    .raw_i (sensor_raw),
    .filt_o(filt)
  );

  assign filt_rise = filt & ~filt_prev_q;
  assign green     = is_green(light_t'(light_farmway));

  // Fault is raised on the same edge the run length reaches the limit; a low
  // filt forces the next count to zero, so it can never re-trigger FAULT.
  always_comb begin
    stuck_cnt_d = '0;
    if (filt) begin
      stuck_cnt_d = (stuck_cnt_q == ST_W'(STUCK_CYCLES)) ? stuck_cnt_q
                                                          : stuck_cnt_q + ST_W'(1);
    end
  end
  assign stuck_hit = (stuck_cnt_d == ST_W'(STUCK_CYCLES));

  always_comb begin
    vcnt_d = vcnt_q;
    if (filt_rise && (state_q != FAULT) && (vcnt_q != '1)) begin
      vcnt_d = vcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (filt_rise) state_d = CALL;
      CALL:    if (green)     state_d = SERVED;
      SERVED:  if (!green)    state_d = filt ? CALL : IDLE;
      FAULT:   if (!filt)     state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (stuck_hit) begin
      state_d = FAULT;
    end
  end

  always_comb begin
    sensor_d = 1'b0;
    case (state_d)
      IDLE:    sensor_d = 1'b0;
      CALL:    sensor_d = 1'b1;
      SERVED:  sensor_d = filt;
      FAULT:   sensor_d = 1'b1;
      default: sensor_d = 1'b0;
    endcase
    stuck_fault = (state_q == FAULT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_prev_q <= 1'b0;
      stuck_cnt_q <= '0;
      vcnt_q      <= '0;
      sensor_q    <= 1'b0;
    end else begin
      filt_prev_q <= filt;
      stuck_cnt_q <= stuck_cnt_d;
      vcnt_q      <= vcnt_d;
      sensor_q    <= sensor_d;
    end
  end

  assign sensor        = sensor_q;
  assign vehicle_count = vcnt_q;

endmodule

// File: tb/tb_farmway_sensor_conditioner.sv
// Directed bench for farmway_sensor_conditioner: DEBOUNCE_CYCLES=4, STUCK_CYCLES=64,
// a CNT_W=8 instance and a CNT_W=2 instance sharing the same stimulus.
module tb_farmway_sensor_conditioner;

  localparam logic [2:0] L_GREEN = 3'b001;
  localparam logic [2:0] L_RED   = 3'b100;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sensor_raw;
  logic [2:0] light_farmway;
  logic       sensor;
  logic [7:0] vehicle_count;
  logic       stuck_fault;
  logic       sensor_s;
  logic [1:0] vehicle_count_s;
  logic       stuck_fault_s;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #10 clk = ~clk;

  farmway_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (64),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sensor_raw   (sensor_raw),
    .light_farmway(light_farmway),
    .sensor       (sensor),
    .vehicle_count(vehicle_count),
    .stuck_fault  (stuck_fault)
  );

  farmway_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (64),
    .CNT_W          (2)
  ) dut_sat (
    .clk          (clk),
    .rstn         (rstn),
    .sensor_raw   (sensor_raw),
    .light_farmway(light_farmway),
    .sensor       (sensor_s),
    .vehicle_count(vehicle_count_s),
    .stuck_fault  (stuck_fault_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rstn          = 1'b0;
    sensor_raw    = 1'b0;
    light_farmway = L_RED;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  initial begin
    rstn          = 1'b0;
    sensor_raw    = 1'b0;
    light_farmway = L_RED;

    // Reset held: raw toggles must not reach the outputs.
    #2 sensor_raw = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_sensor_a", 32'(sensor), 0);
    check_eq("rst_count_a", 32'(vehicle_count), 0);
    check_eq("rst_stuck_a", 32'(stuck_fault), 0);
    sensor_raw = 1'b0;
    #4 sensor_raw = 1'b1;
    #4;
    check_eq("rst_sensor_b", 32'(sensor), 0);
    check_eq("rst_count_b", 32'(vehicle_count), 0);
    check_eq("rst_stuck_b", 32'(stuck_fault), 0);
    sensor_raw = 1'b0;
    #1 rstn = 1'b1;
    tick(1);
    check_eq("rel_sensor", 32'(sensor), 0);

    // Glitch of 3 cycles is filtered out.
    sensor_raw = 1'b1;
    tick(3);
    sensor_raw = 1'b0;
    tick(3);
    check_eq("glitch_sensor_mid", 32'(sensor), 0);
    tick(7);
    check_eq("glitch_sensor", 32'(sensor), 0);
    check_eq("glitch_count", 32'(vehicle_count), 0);

    // Arrival: sensor rises on edge 7 and stays latched after raw falls.
    sensor_raw = 1'b1;
    tick(6);
    check_eq("arr_sensor_e6", 32'(sensor), 0);
    check_eq("arr_count_e6", 32'(vehicle_count), 0);
    tick(1);
    check_eq("arr_sensor_e7", 32'(sensor), 1);
    check_eq("arr_count_e7", 32'(vehicle_count), 1);
    tick(3);
    sensor_raw = 1'b0;
    tick(10);
    check_eq("arr_latched", 32'(sensor), 1);
    check_eq("arr_count", 32'(vehicle_count), 1);
    check_eq("arr_stuck", 32'(stuck_fault), 0);

    // Service with filt low: green clears the call, red returns to idle.
    light_farmway = L_GREEN;
    tick(1);
    check_eq("svc_green_lo", 32'(sensor), 0);
    light_farmway = L_RED;
    tick(1);
    check_eq("svc_red_lo", 32'(sensor), 0);
    tick(2);
    check_eq("svc_idle_hold", 32'(sensor), 0);

    // Service with raw held high: green extends, red returns to CALL.
    sensor_raw = 1'b1;
    tick(7);
    check_eq("svc2_sensor", 32'(sensor), 1);
    check_eq("svc2_count", 32'(vehicle_count), 2);
    light_farmway = L_GREEN;
    tick(1);
    check_eq("svc2_green_hi", 32'(sensor), 1);
    light_farmway = L_RED;
    tick(1);
    check_eq("svc2_red_hi", 32'(sensor), 1);
    sensor_raw = 1'b0;
    tick(10);
    check_eq("svc2_call_latched", 32'(sensor), 1);

    // Asynchronous reset mid-CALL, asserted away from the clock edge.
    @(posedge clk);
    #5 rstn = 1'b0;
    #1;
    check_eq("arst_sensor", 32'(sensor), 0);
    check_eq("arst_count", 32'(vehicle_count), 0);
    check_eq("arst_stuck", 32'(stuck_fault), 0);
    tick(1);
    rstn = 1'b1;
    tick(1);

    // Stuck detector: fault on edge 70 (filt high from edge 6, 64 cycles).
    sensor_raw = 1'b1;
    tick(7);
    check_eq("stk_sensor_e7", 32'(sensor), 1);
    check_eq("stk_count_e7", 32'(vehicle_count), 1);
    tick(62);
    check_eq("stk_fault_e69", 32'(stuck_fault), 0);
    tick(1);
    check_eq("stk_fault_e70", 32'(stuck_fault), 1);
    check_eq("stk_sensor_e70", 32'(sensor), 1);
    tick(10);
    sensor_raw = 1'b0;
    check_eq("stk_count", 32'(vehicle_count), 1);
    tick(6);
    check_eq("stk_fault_hold", 32'(stuck_fault), 1);
    check_eq("stk_sensor_hold", 32'(sensor), 1);
    tick(1);
    check_eq("stk_fault_clear", 32'(stuck_fault), 0);
    check_eq("stk_sensor_clear", 32'(sensor), 0);
    check_eq("stk_count_final", 32'(vehicle_count), 1);

    // Saturation: 5 clean arrivals, the 2-bit counter stops at 3.
    apply_reset();
    for (int unsigned i = 1; i <= 5; i++) begin
      sensor_raw = 1'b1;
      tick(8);
      sensor_raw = 1'b0;
      tick(8);
      check_eq($sformatf("sat_count8_%0d", i), 32'(vehicle_count), i);
      check_eq($sformatf("sat_count2_%0d", i), 32'(vehicle_count_s), (i > 3) ? 3 : i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/farmway_sensor_conditioner.md
# farmway_sensor_conditioner

Upstream front end for `traffic_light_controller_Mealy`. Takes the raw asynchronous farm-road vehicle detector, synchronises and debounces it, and latches a vehicle call until the farmway is served. Drives the controller's `sensor` input and watches its `light_farmway` output as service feedback. Also flags a detector stuck high and counts qualified arrivals.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 8: consecutive stable synchronised samples needed to flip the filtered level (≥2).
- `STUCK_CYCLES`, 1024: consecutive filtered-high cycles that declare a stuck detector (> `DEBOUNCE_CYCLES`).
- `CNT_W`, 8: width of `vehicle_count`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rstn` in 1: reset; one clock; reset is asynchronous and active-low.
- `sensor_raw` in 1: raw detector, asynchronous to `clk`.
- `light_farmway` in 3: controller farmway light, same clock domain; GREEN=3'b001, YELLOW=3'b010, RED=3'b100.
- `sensor` out 1: registered vehicle call to the controller.
- `vehicle_count` out CNT_W: saturating count of qualified arrivals.
- `stuck_fault` out 1: detector stuck-high flag.

## Operation
- Synchroniser: 2 flops, reset 0, output `s_sync`.
- Debounce: register `filt` (reset 0) and counter `db_cnt`.
  - When `s_sync != filt`, `db_cnt` increments.
  - When `s_sync == filt`, `db_cnt` clears.
  - When `db_cnt` reaches `DEBOUNCE_CYCLES-1` with `s_sync != filt`, `filt` toggles and `db_cnt` clears.
- Stuck counter: counts consecutive `filt`=1 cycles, saturates at `STUCK_CYCLES`, clears when `filt`=0.
- FSM states and transitions:
  - IDLE: rising edge of `filt` → CALL.
  - CALL: `light_farmway`==GREEN → SERVED. A `filt` drop does not exit CALL (latched call).
  - SERVED: `light_farmway`!=GREEN → CALL if `filt`=1, else IDLE.
  - FAULT: `filt`=0 → IDLE.
  - Any state: stuck counter reaches `STUCK_CYCLES` → FAULT. This has priority over every other transition.
- `sensor` (registered, next-state based): IDLE 0, CALL 1, SERVED `filt` (extends green while vehicles remain), FAULT 1 (fail-safe; the controller keeps cycling).
- `stuck_fault` = 1 exactly while in FAULT.
- `vehicle_count` increments on each `filt` rising edge that occurs outside FAULT, and saturates at all-ones.
- Simultaneous events:
  - `filt` rise in IDLE while already GREEN → CALL, then SERVED on the next edge.
  - `filt` rise in SERVED → stays SERVED.
- Invalid `light_farmway` codes are treated as not GREEN.

## Timing
- All outputs reset to 0; the FSM resets to IDLE, and all counters and `filt` reset to 0.
- Reset is asynchronous: assertion takes effect immediately, including mid-CALL or mid-FAULT.
- Latency, `sensor_raw` edge to `filt` change: `DEBOUNCE_CYCLES+2` rising edges, counted from the first edge sampling the new level.
- `sensor` and `vehicle_count` update one edge after `filt` changes.
- `light_farmway` affects `sensor` one edge after it is sampled.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `filt`.
- A `vehicle_count` increment at all-ones holds the value.

## Structure
- Shared package `traffic_pkg`:
  - light encoding constants GREEN/YELLOW/RED;
  - sensor FSM state enum IDLE/CALL/SERVED/FAULT;
  - the same light constants, to be adopted by the controller.
- Sub-module `sensor_debounce`: synchroniser plus debounce counter, `filt` output, parameter `DEBOUNCE_CYCLES`. The FSM, stuck counter and vehicle counter live in the top.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `STUCK_CYCLES`=64, 50 MHz clock, `rstn` released at 20 ns.
- Reset: toggle `sensor_raw` while `rstn`=0 → `sensor`=0, `vehicle_count`=0, `stuck_fault`=0 throughout. Assert `rstn`=0 mid-CALL → all outputs 0 immediately.
- Glitch: `sensor_raw`=1 for 3 cycles, `light_farmway`=RED → `sensor` stays 0, `vehicle_count`=0.
- Arrival: `sensor_raw`=1 for 10 cycles, then 0, `light_farmway`=RED → `sensor` rises on edge 7 after the raw rise and stays 1 after raw falls; `vehicle_count`=1.
- Service: from CALL with `filt`=0, drive `light_farmway`=GREEN → `sensor`=0 one edge later. Drive RED → IDLE with `sensor` still 0. Repeat with raw held high → returns to CALL with `sensor`=1.
- Stuck: `sensor_raw`=1 for 80 cycles → `stuck_fault`=1 and `sensor`=1 once 64 filtered-high cycles elapse; `vehicle_count`=1. Then raw=0 → `stuck_fault` and `sensor` drop 7 edges later.
- Saturation: with `CNT_W`=2, issue 5 clean arrivals → `vehicle_count`=3.
